axis_frame_arbiter: RTL

AXIS_FRAME_ARBITER -- requirements
Module: axis_frame_arbiter

---
 rtl/axis_frame_arbiter.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/axis_frame_arbiter.sv
// Selects one of two AXI-Stream video sources per frame and repairs short, long and early-SOF lines.
// Latency: zero (combinational pass-through); backpressure: m_tready passes straight to the selected source, the other source is held off.
module axis_frame_arbiter #(
    parameter int DATA_WIDTH = 16,
    parameter int H_ACTIVE   = 640,
    parameter int V_ACTIVE   = 480
) (
    input  logic                  axi_clk,
    input  logic                  axi_rstn,
    input  logic                  enable,
    input  logic                  sel_req,
    input  logic [DATA_WIDTH-1:0] s0_tdata,
    input  logic                  s0_tvalid,
    input  logic                  s0_tuser,
    input  logic                  s0_tlast,
    output logic                  s0_tready,
    input  logic [DATA_WIDTH-1:0] s1_tdata,
    input  logic                  s1_tvalid,
    input  logic                  s1_tuser,
    input  logic                  s1_tlast,
    output logic                  s1_tready,
    output logic [DATA_WIDTH-1:0] m_tdata,
    output logic                  m_tvalid,
    output logic                  m_tuser,
    output logic                  m_tlast,
    input  logic                  m_tready,
    output logic                  cur_src,
    output logic                  frame_done,
    output logic [15:0]           short_cnt,
    output logic [15:0]           long_cnt,
    output logic [15:0]           sof_err_cnt
);
    localparam int XW = (H_ACTIVE > 1) ? $clog2(H_ACTIVE) : 1;
    localparam int YW = (V_ACTIVE > 1) ? $clog2(V_ACTIVE) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(H_ACTIVE - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(V_ACTIVE - 1);

    typedef enum logic [2:0] {IDLE, SYNC, PASS, PAD, DROP, FILL} state_t;

    state_t          r_state;
    logic [XW-1:0]   r_x;
    logic [YW-1:0]   r_y;
    logic            r_cur_src;
    logic [15:0]     r_short_cnt;
    logic [15:0]     r_long_cnt;
    logic [15:0]     r_sof_err_cnt;

    logic [DATA_WIDTH-1:0] w_s_tdata;
    logic            w_s_tvalid;
    logic            w_s_tuser;
    logic            w_s_tlast;
    logic            w_s_tready;
    logic            w_x_last;
    logic            w_y_last;
    logic            w_first;
    logic            w_early_sof;
    logic            w_m_hs;
    logic            w_s_hs;
    logic            w_eof;

    always_comb begin
        w_s_tdata   = r_cur_src ? s1_tdata  : s0_tdata;
        w_s_tvalid  = r_cur_src ? s1_tvalid : s0_tvalid;
        w_s_tuser   = r_cur_src ? s1_tuser  : s0_tuser;
        w_s_tlast   = r_cur_src ? s1_tlast  : s0_tlast;
        w_x_last    = (r_x == X_LAST);
        w_y_last    = (r_y == Y_LAST);
        w_first     = (r_x == '0) && (r_y == '0);
        w_early_sof = (r_state == PASS) && w_s_tvalid && w_s_tuser && !w_first;

        w_s_tready  = 1'b0;
        m_tvalid    = 1'b0;
        m_tdata     = '0;
        m_tuser     = 1'b0;
        m_tlast     = 1'b0;
        case (r_state)
            // A SOF beat is held back here so PASS can forward it as pixel (0,0).
            SYNC, DROP: w_s_tready = !(w_s_tvalid && w_s_tuser);
            PASS: begin
                if (!w_early_sof) begin
                    m_tvalid   = w_s_tvalid;
                    m_tdata    = w_s_tdata;
                    m_tuser    = w_first;
                    m_tlast    = w_x_last;
                    w_s_tready = m_tready;
                end
            end
            PAD, FILL: begin
                m_tvalid = 1'b1;
                m_tuser  = w_first;
                m_tlast  = w_x_last;
            end
            default: ;
        endcase

        w_m_hs     = m_tvalid && m_tready;
        w_s_hs     = w_s_tvalid && w_s_tready;
        w_eof      = w_m_hs && w_x_last && w_y_last;
        s0_tready  = w_s_tready && !r_cur_src;
        s1_tready  = w_s_tready && r_cur_src;
        frame_done = w_eof;
    end

    always_ff @(posedge axi_clk or negedge axi_rstn) begin
        if (!axi_rstn) begin
            r_state       <= IDLE;
            r_x           <= '0;
            r_y           <= '0;
            r_cur_src     <= 1'b0;
            r_short_cnt   <= '0;
            r_long_cnt    <= '0;
            r_sof_err_cnt <= '0;
        end else if (w_eof) begin
            // Frame boundary is the only point where the source may switch.
            r_x       <= '0;
            r_y       <= '0;
            r_cur_src <= sel_req;
            r_state   <= enable ? SYNC : IDLE;
        end else begin
            case (r_state)
                IDLE: begin
                    if (enable) begin
                        r_state   <= SYNC;
                        r_cur_src <= sel_req;
                        r_x       <= '0;
                        r_y       <= '0;
                    end
                end
                SYNC: begin
                    if (!enable) begin
                        r_state <= IDLE;
                    end else if (w_s_tvalid && w_s_tuser) begin
                        r_state <= PASS;
                        r_x     <= '0;
                        r_y     <= '0;
                    end
                end
                PASS: begin
                    if (w_early_sof) begin
                        r_sof_err_cnt <= r_sof_err_cnt + 16'd1;
                        r_state       <= FILL;
                    end else if (w_m_hs) begin
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                            if (!w_s_tlast) begin
                                r_long_cnt <= r_long_cnt + 16'd1;
                                r_state    <= DROP;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                            if (w_s_tlast) begin
                                r_short_cnt <= r_short_cnt + 16'd1;
                                r_state     <= PAD;
                            end
                        end
                    end
                end
                PAD, FILL: begin
                    if (w_m_hs) begin
                        if (w_x_last) begin
                            r_x <= '0;
                            r_y <= r_y + 1'b1;
                            if (r_state == PAD) begin
                                r_state <= PASS;
                            end
                        end else begin
                            r_x <= r_x + 1'b1;
                        end
                    end
                end
                DROP: begin
                    if (w_s_tvalid && w_s_tuser) begin
                        r_state <= FILL;
                    end else if (w_s_hs && w_s_tlast) begin
                        r_state <= PASS;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign cur_src     = r_cur_src;
    assign short_cnt   = r_short_cnt;
    assign long_cnt    = r_long_cnt;
    assign sof_err_cnt = r_sof_err_cnt;

endmodule
